if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, single-outstanding instruction-memory request FSM, IF/ID pipeline register.
- Consumes the hazard unit's stall[1:0] (PC, IF_ID) and flushIF, plus the branch/jump redirect from ID/EX.
- Produces the IF/ID instruction, PC and PC+4 for decode; inserts bubbles when memory is slow, stalled or flushed.

---
 rtl/mips_pipe_pkg.sv | 31 +++
 rtl/if_fetch_stage_if.sv | 27 ++
 rtl/if_fetch_stage_if_id_reg.sv | 38 +++
 rtl/if_fetch_stage.sv | 189 ++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types for the MIPS front end: fetch FSM states, IF/ID record
// and the bubble encoding used by every stage register.
package mips_pipe_pkg;

    localparam int unsigned PIPE_ADDR_W     = 32;
    localparam int unsigned PIPE_INSTR_W    = 32;
    localparam int unsigned DEFAULT_PC_STEP = 4;

    localparam logic [PIPE_INSTR_W-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

    typedef struct packed {
        logic                    valid;
        logic [PIPE_INSTR_W-1:0] instr;
        logic [PIPE_ADDR_W-1:0]  pc;
        logic [PIPE_ADDR_W-1:0]  pc4;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        valid: 1'b0,
        instr: NOP_INSTR,
        pc:    '0,
        pc4:   '0
    };

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface if_fetch_stage_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
) ();

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load beats hold; anything else is a bubble.
module if_id_reg
    import mips_pipe_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   flush_i,
    input  logic   load_i,
    input  logic   hold_i,
    input  if_id_t data_i,
    output if_id_t q_o
);

    if_id_t ifid_q;
    if_id_t ifid_d;

    always_comb begin
        ifid_d = IF_ID_BUBBLE;
        if (flush_i) begin
            ifid_d = IF_ID_BUBBLE;
        end else if (load_i) begin
            ifid_d = data_i;
        end else if (hold_i) begin
            ifid_d = ifid_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_q <= IF_ID_BUBBLE;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign q_o = ifid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC, single-outstanding imem request FSM, IF/ID.
// Define FETCH_PERF_EN to add saturating fetch/stall/kill performance counters.
module if_fetch_stage
    import mips_pipe_pkg::*;
#(
    parameter int unsigned       ADDR_W   = PIPE_ADDR_W,
    parameter int unsigned       INSTR_W  = PIPE_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_pc,
    input  logic                stall_ifid,
    input  logic                flush_if,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    if_fetch_stage_if.master    imem,
    output logic                if_id_valid,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [ADDR_W-1:0]   if_id_pc,
    output logic [ADDR_W-1:0]   if_id_pc4,
    output logic                fetch_busy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_kill_cnt
`endif
);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc_plus;
    logic               kill_q, kill_d;
    logic [INSTR_W-1:0] hold_q, hold_d;

    logic               resp_drop;
    logic               hold_drop;
    logic               load_ifid;
    logic               capture;
    logic               advance;
    logic [INSTR_W-1:0] load_instr;

    if_id_t             ifid_in;
    if_id_t             ifid_q;

    assign pc_plus   = pc_q + ADDR_W'(PC_STEP);
    assign resp_drop = kill_q | redirect_valid | flush_if;
    assign hold_drop = redirect_valid | flush_if;

    // State register plus the PC / kill / hold-buffer datapath it steers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            hold_q  <= hold_d;
        end
    end

    // A redirect in REQ or in WAIT-without-response arms kill so the response
    // already in flight for the old PC is dropped when it lands.
    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        load_ifid  = 1'b0;
        capture    = 1'b0;
        advance    = 1'b0;
        load_instr = imem.imem_rdata;
        unique case (state_q)
            REQ: begin
                state_d = WAIT;
                kill_d  = redirect_valid;
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    state_d = REQ;
                    kill_d  = 1'b0;
                    if (!resp_drop) begin
                        if (!stall_ifid) begin
                            load_ifid = 1'b1;
                            advance   = 1'b1;
                        end else begin
                            capture = 1'b1;
                            state_d = HOLD;
                        end
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (hold_drop) begin
                    state_d = REQ;
                end else if (!stall_ifid) begin
                    load_ifid  = 1'b1;
                    advance    = 1'b1;
                    load_instr = hold_q;
                    state_d    = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_comb begin
        imem.imem_req = 1'b0;
        fetch_busy    = 1'b0;
        unique case (state_q)
            REQ:     imem.imem_req = !rst;
            WAIT:    fetch_busy    = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (advance && !stall_pc) begin
            pc_d = pc_plus;
        end
        hold_d = capture ? imem.imem_rdata : hold_q;
    end

    assign imem.imem_addr = {pc_q[ADDR_W-1:2], 2'b00};

    always_comb begin
        ifid_in       = IF_ID_BUBBLE;
        ifid_in.valid = 1'b1;
        ifid_in.instr = PIPE_INSTR_W'(load_instr);
        ifid_in.pc    = PIPE_ADDR_W'(pc_q);
        ifid_in.pc4   = PIPE_ADDR_W'(pc_plus);
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_if),
        .load_i  (load_ifid),
        .hold_i  (stall_ifid),
        .data_i  (ifid_in),
        .q_o     (ifid_q)
    );

    assign if_id_valid = ifid_q.valid;
    assign if_id_instr = INSTR_W'(ifid_q.instr);
    assign if_id_pc    = ADDR_W'(ifid_q.pc);
    assign if_id_pc4   = ADDR_W'(ifid_q.pc4);

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_kill_q;
    logic        drop_evt;

    assign drop_evt = ((state_q == WAIT) && imem.imem_rvalid && resp_drop) ||
                      ((state_q == HOLD) && hold_drop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
            perf_kill_q  <= '0;
        end else begin
            if (load_ifid && (perf_fetch_q != '1)) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (stall_ifid && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (drop_evt && (perf_kill_q != '1)) begin
                perf_kill_q <= perf_kill_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
    assign perf_kill_cnt  = perf_kill_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed, table-driven bench for if_fetch_stage: each row gives the inputs for
// one cycle and the outputs expected during that cycle (before its rising edge).
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall_pc;
    logic        stall_ifid;
    logic        flush_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        fetch_busy;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_kill_cnt;
`endif

    int n_tests;
    int n_fail;

    if_fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

    if_fetch_stage #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_pc       (stall_pc),
        .stall_ifid     (stall_ifid),
        .flush_if       (flush_if),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .fetch_busy     (fetch_busy)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_kill_cnt  (perf_kill_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctl;    // {stall_pc, stall_ifid, flush_if, redirect_valid}
        logic [31:0] rpc;
        logic        mv;
        logic [31:0] md;
        logic        req;
        logic [31:0] addr;
        logic        busy;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] ipc;
    } vec_t;

    vec_t tbl[$];
    vec_t wrap_seq[$];

    function automatic vec_t mk(input logic [3:0] ctl, input logic [31:0] rpc,
                                input logic mv, input logic [31:0] md,
                                input logic req, input logic [31:0] addr,
                                input logic busy, input logic vld,
                                input logic [31:0] instr, input logic [31:0] ipc);
        vec_t v;
        v.ctl = ctl;  v.rpc = rpc;   v.mv = mv;     v.md = md;
        v.req = req;  v.addr = addr; v.busy = busy; v.vld = vld;
        v.instr = instr; v.ipc = ipc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        {stall_pc, stall_ifid, flush_if, redirect_valid} = v.ctl;
        redirect_pc     = v.rpc;
        bus.imem_rvalid = v.mv;
        bus.imem_rdata  = v.md;
        #1;
        chk({tag, " req"},   {31'b0, bus.imem_req}, {31'b0, v.req});
        chk({tag, " addr"},  bus.imem_addr, v.addr);
        chk({tag, " busy"},  {31'b0, fetch_busy}, {31'b0, v.busy});
        chk({tag, " valid"}, {31'b0, if_id_valid}, {31'b0, v.vld});
        chk({tag, " instr"}, if_id_instr, v.instr);
        chk({tag, " pc"},    if_id_pc, v.ipc);
        chk({tag, " pc4"},   if_id_pc4, v.vld ? v.ipc + 32'd4 : 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req"},   {31'b0, bus.imem_req}, 32'd0);
        chk({tag, " addr"},  bus.imem_addr, 32'd0);
        chk({tag, " busy"},  {31'b0, fetch_busy}, 32'd0);
        chk({tag, " valid"}, {31'b0, if_id_valid}, 32'd0);
        chk({tag, " instr"}, if_id_instr, 32'd0);
        chk({tag, " pc"},    if_id_pc, 32'd0);
        chk({tag, " pc4"},   if_id_pc4, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // zero-wait memory, rdata = addr + 0x100
        tbl.push_back(mk(4'b0000, 32'h0,   1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 1'b0, 32'h0,   32'h0));
        tbl.push_back(mk(4'b0000, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000, 1'b1, 1'b0, 32'h0,   32'h0));
        tbl.push_back(mk(4'b0000, 32'h0,   1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 1'b1, 32'h100, 32'h0));
        tbl.push_back(mk(4'b0000, 32'h0,   1'b1, 32'h104, 1'b0, 32'h004, 1'b1, 1'b0, 32'h0,   32'h0));
        tbl.push_back(mk(4'b0000, 32'h0,   1'b0, 32'h0,   1'b1, 32'h008, 1'b0, 1'b1, 32'h104, 32'h4));
        tbl.push_back(mk(4'b0000, 32'h0,   1'b1, 32'h108, 1'b0, 32'h008, 1'b1, 1'b0, 32'h0,   32'h0));
        tbl.push_back(mk(4'b0000, 32'h0,   1'b0, 32'h0,   1'b1, 32'h00C, 1'b0, 1'b1, 32'h108, 32'h8));
        // response delayed: three WAIT cycles, bubbles, pc held
        tbl.push_back(mk(4'b0000, 32'h0,   1'b0, 32'h0,   1'b0, 32'h00C, 1'b1, 1'b0, 32'h0,   32'h0));
        tbl.push_back(mk(4'b0000, 32'h0,   1'b0, 32'h0,   1'b0, 32'h00C, 1'b1, 1'b0, 32'h0,   32'h0));
        tbl.push_back(mk(4'b0000, 32'h0,   1'b1, 32'h10C, 1'b0, 32'h00C, 1'b1, 1'b0, 32'h0,   32'h0));
        // four-cycle stall of PC and IF/ID with the response landing in HOLD
        tbl.push_back(mk(4'b1100, 32'h0,   1'b0, 32'h0,   1'b1, 32'h010, 1'b0, 1'b1, 32'h10C, 32'hC));
        tbl.push_back(mk(4'b1100, 32'h0,   1'b1, 32'h110, 1'b0, 32'h010, 1'b1, 1'b1, 32'h10C, 32'hC));
        tbl.push_back(mk(4'b1100, 32'h0,   1'b0, 32'h0,   1'b0, 32'h010, 1'b0, 1'b1, 32'h10C, 32'hC));
        tbl.push_back(mk(4'b1100, 32'h0,   1'b0, 32'h0,   1'b0, 32'h010, 1'b0, 1'b1, 32'h10C, 32'hC));
        tbl.push_back(mk(4'b0000, 32'h0,   1'b0, 32'h0,   1'b0, 32'h010, 1'b0, 1'b1, 32'h10C, 32'hC));
        tbl.push_back(mk(4'b0000, 32'h0,   1'b0, 32'h0,   1'b1, 32'h014, 1'b0, 1'b1, 32'h110, 32'h10));
        // redirect to 0x400 while waiting; stale 0x114 response must vanish
        tbl.push_back(mk(4'b0001, 32'h400, 1'b0, 32'h0,   1'b0, 32'h014, 1'b1, 1'b0, 32'h0,   32'h0));
        tbl.push_back(mk(4'b0000, 32'h0,   1'b1, 32'h114, 1'b0, 32'h400, 1'b1, 1'b0, 32'h0,   32'h0));
        tbl.push_back(mk(4'b0000, 32'h0,   1'b0, 32'h0,   1'b1, 32'h400, 1'b0, 1'b0, 32'h0,   32'h0));
        tbl.push_back(mk(4'b0000, 32'h0,   1'b1, 32'h500, 1'b0, 32'h400, 1'b1, 1'b0, 32'h0,   32'h0));
        // flush + stall + response together: flush wins, refetch same pc
        tbl.push_back(mk(4'b0100, 32'h0,   1'b0, 32'h0,   1'b1, 32'h404, 1'b0, 1'b1, 32'h500, 32'h400));
        tbl.push_back(mk(4'b0110, 32'h0,   1'b1, 32'h504, 1'b0, 32'h404, 1'b1, 1'b1, 32'h500, 32'h400));
        tbl.push_back(mk(4'b0000, 32'h0,   1'b0, 32'h0,   1'b1, 32'h404, 1'b0, 1'b0, 32'h0,   32'h0));
        tbl.push_back(mk(4'b0000, 32'h0,   1'b1, 32'h504, 1'b0, 32'h404, 1'b1, 1'b0, 32'h0,   32'h0));
        // redirect during REQ kills the request just issued
        tbl.push_back(mk(4'b0001, 32'h800, 1'b0, 32'h0,   1'b1, 32'h408, 1'b0, 1'b1, 32'h504, 32'h404));
        tbl.push_back(mk(4'b0000, 32'h0,   1'b1, 32'h508, 1'b0, 32'h800, 1'b1, 1'b0, 32'h0,   32'h0));
        tbl.push_back(mk(4'b0000, 32'h0,   1'b0, 32'h0,   1'b1, 32'h800, 1'b0, 1'b0, 32'h0,   32'h0));
        tbl.push_back(mk(4'b0000, 32'h0,   1'b1, 32'h900, 1'b0, 32'h800, 1'b1, 1'b0, 32'h0,   32'h0));
        tbl.push_back(mk(4'b0100, 32'h0,   1'b0, 32'h0,   1'b1, 32'h804, 1'b0, 1'b1, 32'h900, 32'h800));

        // after a mid-WAIT reset: jump to the top word and wrap the PC
        wrap_seq.push_back(mk(4'b0001, 32'hFFFF_FFFC, 1'b0, 32'h0,    1'b1, 32'h0,         1'b0, 1'b0, 32'h0,    32'h0));
        wrap_seq.push_back(mk(4'b0000, 32'h0,         1'b1, 32'hDEAD, 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,    32'h0));
        wrap_seq.push_back(mk(4'b0000, 32'h0,         1'b0, 32'h0,    1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,    32'h0));
        wrap_seq.push_back(mk(4'b0000, 32'h0,         1'b1, 32'hCAFE, 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,    32'h0));
        wrap_seq.push_back(mk(4'b0000, 32'h0,         1'b0, 32'h0,    1'b1, 32'h0,         1'b0, 1'b1, 32'hCAFE, 32'hFFFF_FFFC));

        rst            = 1'b1;
        stall_pc       = 1'b0;
        stall_ifid     = 1'b0;
        flush_if       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;

        @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // now in WAIT for 0x804 with IF/ID held at 0x900
        {stall_pc, stall_ifid, flush_if, redirect_valid} = 4'b0000;
        bus.imem_rvalid = 1'b0;
        #1;
        chk("pre-reset busy",  {31'b0, fetch_busy}, 32'd1);
        chk("pre-reset valid", {31'b0, if_id_valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async-reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (wrap_seq[i]) apply(wrap_seq[i], $sformatf("wrap%0d", i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
